// File: rtl/core_pkg.sv
// core_pkg
//   Shared constants for the RV32I pipeline. The hazard unit, the ID-stage
//   decoder and the EX operand muxes all use these encodings.
//   HZ_*  : 2-bit hazard operation type carried with each instruction.
//   FWD_* : 2-bit operand source select driven into the EX operand muxes.
package core_pkg;

   localparam logic [1:0] HZ_NONE  = 2'b00;
   localparam logic [1:0] HZ_ALU   = 2'b01;
   localparam logic [1:0] HZ_LOAD  = 2'b10;
   localparam logic [1:0] HZ_STORE = 2'b11;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_EXE     = 2'b01;
   localparam logic [1:0] FWD_MEM_ALU = 2'b10;
   localparam logic [1:0] FWD_MEM_LD  = 2'b11;

   // Only ALU ops and loads write the register file, so only they act as producers.
   function automatic logic hz_is_writer(input logic [1:0] optype);
      return (optype == HZ_ALU) || (optype == HZ_LOAD);
   endfunction

endpackage

// File: rtl/hazard_detect_unit_tracker.sv
// hazard_stage_tracker
//   Holds the hazard-relevant fields of the instructions in EXE and MEM.
//   Every clock, MEM takes over EXE, and EXE takes the ID fields or a
//   bubble (all fields zero) when bubble=1. rst clears both stages
//   asynchronously.
//   Ports:
//     clk, rst             clock, async active-high reset
//     bubble               insert a bubble into EXE instead of the ID fields
//     optype_id/rd_id/rs2_id   fields of the instruction leaving ID
//     optype_e/rd_e/rs2_e      current EXE occupant
//     optype_m/rd_m            current MEM occupant
module hazard_stage_tracker
   import core_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bubble,
   input  logic [1:0]        optype_id,
   input  logic [REG_AW-1:0] rd_id,
   input  logic [REG_AW-1:0] rs2_id,
   output logic [1:0]        optype_e,
   output logic [REG_AW-1:0] rd_e,
   output logic [REG_AW-1:0] rs2_e,
   output logic [1:0]        optype_m,
   output logic [REG_AW-1:0] rd_m
);

   logic [1:0]        optype_e_q, optype_e_d;
   logic [REG_AW-1:0] rd_e_q, rd_e_d;
   logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
   logic [1:0]        optype_m_q, optype_m_d;
   logic [REG_AW-1:0] rd_m_q, rd_m_d;

   // Next-state: shift EXE into MEM, load EXE from ID or with a bubble.
   always_comb begin
      optype_m_d = optype_e_q;
      rd_m_d     = rd_e_q;
      optype_e_d = HZ_NONE;
      rd_e_d     = '0;
      rs2_e_d    = '0;
      if (bubble) begin
         optype_e_d = HZ_NONE;
         rd_e_d     = '0;
         rs2_e_d    = '0;
      end else begin
         optype_e_d = optype_id;
         rd_e_d     = rd_id;
         rs2_e_d    = rs2_id;
      end
   end

   // Stage registers; reset state is a bubble in both stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         optype_e_q <= HZ_NONE;
         rd_e_q     <= '0;
         rs2_e_q    <= '0;
         optype_m_q <= HZ_NONE;
         rd_m_q     <= '0;
      end else begin
         optype_e_q <= optype_e_d;
         rd_e_q     <= rd_e_d;
         rs2_e_q    <= rs2_e_d;
         optype_m_q <= optype_m_d;
         rd_m_q     <= rd_m_d;
      end
   end

   assign optype_e = optype_e_q;
   assign rd_e     = rd_e_q;
   assign rs2_e    = rs2_e_q;
   assign optype_m = optype_m_q;
   assign rd_m     = rd_m_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
//   Pipeline hazard unit for the 5-stage RV32I core. Tracks the EXE/MEM
//   occupants and produces load-use stalls, branch flushes and operand
//   forwarding selects. Register file writes in the first half-cycle, so
//   there is no WB forwarding path.
//   Parameters: REG_AW register-address width; FWD_EN 1 forwards from
//   EXE/MEM, 0 stalls on every RAW until the producer leaves MEM.
//   Inputs : clk, rst, Branch_ID, rs1use_ID, rs2use_ID, hazard_optype_ID,
//            rs1_ID, rs2_ID, rd_ID
//   Outputs: PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
//            forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
//   All outputs are combinational from tracked state and ID inputs.
module hazard_detect_unit
   import core_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Branch_ID,
   input  logic              rs1use_ID,
   input  logic              rs2use_ID,
   input  logic [1:0]        hazard_optype_ID,
   input  logic [REG_AW-1:0] rs1_ID,
   input  logic [REG_AW-1:0] rs2_ID,
   input  logic [REG_AW-1:0] rd_ID,
   output logic              PC_EN_IF,
   output logic              reg_FD_EN,
   output logic              reg_FD_flush,
   output logic              reg_DE_flush,
   output logic [1:0]        forward_ctrl_A,
   output logic [1:0]        forward_ctrl_B,
   output logic              forward_ctrl_ls
);

   logic [1:0]        optype_e, optype_m;
   logic [REG_AW-1:0] rd_e, rs2_e, rd_m;
   logic              stall;
   logic              m1_e, m2_e, m1_m, m2_m;

   // A source matches a stage only when it is used, is not x0, and the
   // occupant actually writes that register.
   function automatic logic src_match(input logic use_s, input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rd, input logic [1:0] optype);
      return use_s && (rs != '0) && (rs == rd) && hz_is_writer(optype);
   endfunction

   // EXE result beats MEM result since it is the younger producer.
   function automatic logic [1:0] fwd_sel(input logic me, input logic mm,
                                          input logic [1:0] op_e, input logic [1:0] op_m);
      if (me && (op_e == HZ_ALU)) begin
         return FWD_EXE;
      end else if (mm && (op_m == HZ_ALU)) begin
         return FWD_MEM_ALU;
      end else if (mm && (op_m == HZ_LOAD)) begin
         return FWD_MEM_LD;
      end else begin
         return FWD_RF;
      end
   endfunction

   hazard_stage_tracker #(.REG_AW(REG_AW)) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .bubble    (stall),
      .optype_id (hazard_optype_ID),
      .rd_id     (rd_ID),
      .rs2_id    (rs2_ID),
      .optype_e  (optype_e),
      .rd_e      (rd_e),
      .rs2_e     (rs2_e),
      .optype_m  (optype_m),
      .rd_m      (rd_m)
   );

   assign m1_e = src_match(rs1use_ID, rs1_ID, rd_e, optype_e);
   assign m2_e = src_match(rs2use_ID, rs2_ID, rd_e, optype_e);
   assign m1_m = src_match(rs1use_ID, rs1_ID, rd_m, optype_m);
   assign m2_m = src_match(rs2use_ID, rs2_ID, rd_m, optype_m);

   // Stall, flush and forwarding decisions.
   always_comb begin
      stall           = 1'b0;
      forward_ctrl_A  = FWD_RF;
      forward_ctrl_B  = FWD_RF;
      forward_ctrl_ls = 1'b0;
      if (FWD_EN) begin
         // A store whose only dependency on the load is its data operand
         // can go ahead; the data is picked up via forward_ctrl_ls next cycle.
         stall = (m1_e || m2_e) && (optype_e == HZ_LOAD) &&
                 !((hazard_optype_ID == HZ_STORE) && m2_e && !m1_e);
         forward_ctrl_A  = fwd_sel(m1_e, m1_m, optype_e, optype_m);
         forward_ctrl_B  = fwd_sel(m2_e, m2_m, optype_e, optype_m);
         forward_ctrl_ls = (optype_e == HZ_STORE) && (optype_m == HZ_LOAD) &&
                           (rd_m != '0) && (rs2_e == rd_m);
      end else begin
         stall = m1_e || m2_e || m1_m || m2_m;
      end
      PC_EN_IF     = !stall;
      reg_FD_EN    = !stall;
      reg_DE_flush = stall;
      // Stall wins over a branch: its operands are stale and it is re-evaluated.
      reg_FD_flush = Branch_ID && !stall;
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit: one instance with forwarding, one without.
// Directed scenarios followed by randomized instruction streams, both checked
// against a reference model written in terms of "which older instruction
// produces this source register".
module tb_hazard_detect_unit;
   import core_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic br, u1, u2;
   logic [1:0] op;
   logic [4:0] rs1, rs2, rd;

   logic pc_f, fden_f, fdfl_f, defl_f, ls_f;
   logic [1:0] fa_f, fb_f;
   logic pc_n, fden_n, fdfl_n, defl_n, ls_n;
   logic [1:0] fa_n, fb_n;

   always #5 clk = ~clk;

   hazard_detect_unit #(.REG_AW(5), .FWD_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .Branch_ID(br), .rs1use_ID(u1), .rs2use_ID(u2),
      .hazard_optype_ID(op), .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd),
      .PC_EN_IF(pc_f), .reg_FD_EN(fden_f), .reg_FD_flush(fdfl_f), .reg_DE_flush(defl_f),
      .forward_ctrl_A(fa_f), .forward_ctrl_B(fb_f), .forward_ctrl_ls(ls_f));

   hazard_detect_unit #(.REG_AW(5), .FWD_EN(1'b0)) dut_nf (
      .clk(clk), .rst(rst), .Branch_ID(br), .rs1use_ID(u1), .rs2use_ID(u2),
      .hazard_optype_ID(op), .rs1_ID(rs1), .rs2_ID(rs2), .rd_ID(rd),
      .PC_EN_IF(pc_n), .reg_FD_EN(fden_n), .reg_FD_flush(fdfl_n), .reg_DE_flush(defl_n),
      .forward_ctrl_A(fa_n), .forward_ctrl_B(fb_n), .forward_ctrl_ls(ls_n));

   // Model of the in-flight instructions: index 0 = forwarding DUT, 1 = no-forward DUT.
   typedef struct packed {
      logic [1:0] op;
      logic [4:0] rd;
      logic [4:0] rs2;
   } ent_t;
   ent_t in_exe [2];
   ent_t in_mem [2];

   int n_vec = 0;
   int n_err = 0;

   // Does an in-flight instruction produce register r?
   function automatic bit produces(ent_t e, logic [4:0] r);
      return (r != 5'd0) && (e.rd == r) && (e.op == HZ_ALU || e.op == HZ_LOAD);
   endfunction

   // Expected {PC_EN, FD_EN, FD_flush, DE_flush, fwdA, fwdB, ls}.
   function automatic logic [8:0] expect_out(int inst);
      bit fwd;
      bit used [2];
      logic [4:0] reg_of [2];
      bit dep_e [2];
      bit dep_m [2];
      logic [1:0] src [2];
      bit stall;
      bit ls;
      fwd = (inst == 0);
      used[0] = u1;  reg_of[0] = rs1;
      used[1] = u2;  reg_of[1] = rs2;
      for (int s = 0; s < 2; s++) begin
         dep_e[s] = used[s] && produces(in_exe[inst], reg_of[s]);
         dep_m[s] = used[s] && produces(in_mem[inst], reg_of[s]);
         if (!fwd)                                  src[s] = 2'd0;
         else if (dep_e[s] && in_exe[inst].op == HZ_ALU) src[s] = 2'd1;
         else if (dep_m[s]) src[s] = (in_mem[inst].op == HZ_ALU) ? 2'd2 : 2'd3;
         else                                       src[s] = 2'd0;
      end
      if (fwd) begin
         stall = (in_exe[inst].op == HZ_LOAD) && (dep_e[0] || dep_e[1]);
         if (op == HZ_STORE && !dep_e[0]) stall = 0;
         ls = (in_exe[inst].op == HZ_STORE) && (in_mem[inst].op == HZ_LOAD) &&
              (in_mem[inst].rd != 5'd0) && (in_exe[inst].rs2 == in_mem[inst].rd);
      end else begin
         stall = dep_e[0] || dep_e[1] || dep_m[0] || dep_m[1];
         ls = 0;
      end
      return {~stall, ~stall, br & ~stall, stall, src[0], src[1], ls};
   endfunction

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_fwd"}, {pc_f, fden_f, fdfl_f, defl_f, fa_f, fb_f, ls_f}, expect_out(0));
      chk({tag, "_nofwd"}, {pc_n, fden_n, fdfl_n, defl_n, fa_n, fb_n, ls_n}, expect_out(1));
   endtask

   // Drive one ID instruction and check both DUTs on the falling edge.
   task automatic apply(input string tag, input logic b, input logic a1, input logic a2,
                        input logic [1:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d);
      br = b; u1 = a1; u2 = a2; op = o; rs1 = s1; rs2 = s2; rd = d;
      @(negedge clk);
      chk_model(tag);
   endtask

   // Clock edge: advance the model the way the pipeline moves.
   task automatic adv();
      logic [8:0] e0, e1;
      e0 = expect_out(0);
      e1 = expect_out(1);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         in_mem[k] = in_exe[k];
         in_exe[k] = ((k == 0) ? e0[5] : e1[5]) ? '0 : {op, rd, rs2};
      end
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         in_exe[k] = '0;
         in_mem[k] = '0;
      end
   endtask

   task automatic nop();
      apply("nop", 1'b0, 1'b0, 1'b0, HZ_NONE, 5'd0, 5'd0, 5'd0);
      adv();
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      br = 1'b0; u1 = 1'b1; u2 = 1'b1; op = HZ_ALU; rs1 = 5'd3; rs2 = 5'd4; rd = 5'd6;
      #1;
      chk_model("in_reset");
      chk("reset_pc", {8'd0, pc_f}, 9'd1);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Load-use with a reset pulse arriving mid-cycle.
      apply("t1_lw", 1'b0, 1'b1, 1'b0, HZ_LOAD, 5'd1, 5'd0, 5'd5); adv();
      apply("t1_use", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd5, 5'd1, 5'd7);
      chk("t1_stall_before_rst", {8'd0, pc_f}, 9'd0);
      #1 rst = 1'b1;
      #1;
      model_reset();
      chk_model("t1_in_rst");
      chk("t1_pc_rst", {8'd0, pc_f}, 9'd1);
      chk("t1_fa_rst", {7'd0, fa_f}, 9'd0);
      #1 rst = 1'b0;
      adv();
      nop(); nop();

      // ALU to ALU forwarding from EXE, then from MEM.
      apply("t2_add5", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd1, 5'd2, 5'd5); adv();
      apply("t2_add6", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd5, 5'd5, 5'd6);
      chk("t2_fa_exe", {7'd0, fa_f}, 9'd1);
      chk("t2_fb_exe", {7'd0, fb_f}, 9'd1);
      adv();
      apply("t2_use_mem", 1'b0, 1'b1, 1'b0, HZ_ALU, 5'd5, 5'd0, 5'd8);
      chk("t2_fa_mem", {7'd0, fa_f}, 9'd2);
      adv();
      nop(); nop(); nop();

      // Load-use: one bubble, then MEM load forwarding.
      apply("t3_lw", 1'b0, 1'b1, 1'b0, HZ_LOAD, 5'd1, 5'd0, 5'd5); adv();
      apply("t3_add_c1", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd5, 5'd1, 5'd7);
      chk("t3_stall", {6'd0, pc_f, fden_f, defl_f}, 9'b000000001);
      adv();
      apply("t3_add_c2", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd5, 5'd1, 5'd7);
      chk("t3_fa_ld", {7'd0, fa_f}, 9'd3);
      chk("t3_nostall", {8'd0, pc_f}, 9'd1);
      adv();
      nop(); nop(); nop(); nop();

      // Load then store of the loaded value: no stall, store-data forward.
      apply("t4_lw", 1'b0, 1'b1, 1'b0, HZ_LOAD, 5'd1, 5'd0, 5'd5); adv();
      apply("t4_sw", 1'b0, 1'b1, 1'b1, HZ_STORE, 5'd1, 5'd5, 5'd0);
      chk("t4_nostall", {8'd0, pc_f}, 9'd1);
      adv();
      apply("t4_next", 1'b0, 1'b1, 1'b0, HZ_ALU, 5'd9, 5'd0, 5'd10);
      chk("t4_ls", {8'd0, ls_f}, 9'd1);
      chk("t4_fa", {7'd0, fa_f}, 9'd0);
      adv();
      nop(); nop(); nop(); nop();

      // x0 never forwards; EXE beats MEM when both write the register.
      apply("t5_lw0", 1'b0, 1'b1, 1'b0, HZ_LOAD, 5'd1, 5'd0, 5'd0); adv();
      apply("t5_add0", 1'b0, 1'b1, 1'b1, HZ_ALU, 5'd0, 5'd0, 5'd1);
      chk("t5_x0", {6'd0, pc_f, fa_f}, 9'b000000100);
      adv();
      nop(); nop(); nop();
      apply("t5_a", 1'b0, 1'b1, 1'b0, HZ_ALU, 5'd2, 5'd0, 5'd5); adv();
      apply("t5_b", 1'b0, 1'b1, 1'b0, HZ_ALU, 5'd3, 5'd0, 5'd5); adv();
      apply("t5_use", 1'b0, 1'b1, 1'b0, HZ_ALU, 5'd5, 5'd0, 5'd9);
      chk("t5_prio", {7'd0, fa_f}, 9'd1);
      adv();
      nop(); nop(); nop(); nop();

      // Branch behind a load: stall wins, then the branch flushes.
      apply("t6_lw", 1'b0, 1'b1, 1'b0, HZ_LOAD, 5'd1, 5'd0, 5'd5); adv();
      apply("t6_beq_c1", 1'b1, 1'b1, 1'b1, HZ_NONE, 5'd5, 5'd2, 5'd0);
      chk("t6_c1", {6'd0, pc_f, fdfl_f, defl_f}, 9'b000000001);
      adv();
      apply("t6_beq_c2", 1'b1, 1'b1, 1'b1, HZ_NONE, 5'd5, 5'd2, 5'd0);
      chk("t6_c2", {6'd0, fdfl_f, fa_f}, 9'b000000111);
      adv();

      // Randomized stream over a small register set to provoke frequent hazards.
      for (int i = 0; i < 600; i++) begin
         apply("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
         if (i == 300) begin
            #1 rst = 1'b1;
            #1;
            model_reset();
            chk_model("rand_rst");
            #1 rst = 1'b0;
         end
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
